// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM/WB outputs of the memory stage
interface mem_stage_if;
  logic [31:0] i_ex_m_alu_result;
  logic [31:0] i_ex_m_write_data;
  logic [4:0]  i_ex_m_rd;
  logic        i_ex_m_mem_read;
  logic        i_ex_m_mem_write;
  logic        i_ex_m_mem_to_reg;
  logic        i_ex_m_reg_write;
  logic [2:0]  i_ex_m_bhw_type;
  logic        i_ex_m_halt;
  logic [31:0] o_m_wb_read_data;
  logic [31:0] o_m_wb_alu_result;
  logic [4:0]  o_m_wb_rd;
  logic        o_m_wb_mem_to_reg;
  logic        o_m_wb_reg_write;
  logic        o_m_wb_halt;
  modport master (
    output i_ex_m_alu_result, i_ex_m_write_data, i_ex_m_rd, i_ex_m_mem_read,
           i_ex_m_mem_write, i_ex_m_mem_to_reg, i_ex_m_reg_write, i_ex_m_bhw_type,
           i_ex_m_halt,
    input  o_m_wb_read_data, o_m_wb_alu_result, o_m_wb_rd, o_m_wb_mem_to_reg,
           o_m_wb_reg_write, o_m_wb_halt
  );
  modport slave (
    input  i_ex_m_alu_result, i_ex_m_write_data, i_ex_m_rd, i_ex_m_mem_read,
           i_ex_m_mem_write, i_ex_m_mem_to_reg, i_ex_m_reg_write, i_ex_m_bhw_type,
           i_ex_m_halt,
    output o_m_wb_read_data, o_m_wb_alu_result, o_m_wb_rd, o_m_wb_mem_to_reg,
           o_m_wb_reg_write, o_m_wb_halt
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: data memory access with byte lanes, load extension and MEM/WB register
module mem_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clk_en,
  mem_stage_if.slave        bus,
  input  logic [ADDR_W-1:0] i_du_addr,
  output logic [31:0]       o_du_data,
  output logic              o_mem_fault
);
  logic [31:0]       mem [DEPTH];
  logic [31:0]       addr;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic              is_byte, is_half, is_word, uns;
  logic              misal, fault_now, do_store;
  logic [3:0]        be;
  logic [31:0]       wlane, rword, ext, load;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [31:0]       read_data_d, read_data_q, alu_result_d, alu_result_q;
  logic [4:0]        rd_d, rd_q;
  logic              mem_to_reg_d, mem_to_reg_q, reg_write_d, reg_write_q;
  logic              halt_d, halt_q, fault_d, fault_q;

  // decode the access: word index, lane enables, store lanes, extended load and fault
  always_comb begin
    addr      = bus.i_ex_m_alu_result;
    idx       = addr[ADDR_W+1:2];
    off       = addr[1:0];
    is_byte   = bus.i_ex_m_bhw_type[1:0] == 2'b00;
    is_half   = bus.i_ex_m_bhw_type[1:0] == 2'b01;
    is_word   = bus.i_ex_m_bhw_type[1];
    uns       = bus.i_ex_m_bhw_type[2];
    misal     = (is_half & off[0]) | (is_word & (off != 2'b00));
    fault_now = misal & (bus.i_ex_m_mem_read | bus.i_ex_m_mem_write);
    do_store  = bus.i_ex_m_mem_write & ~misal & i_clk_en;
    be        = is_byte ? 4'b0001 << off : is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wlane     = is_byte ? {4{bus.i_ex_m_write_data[7:0]}} :
                is_half ? {2{bus.i_ex_m_write_data[15:0]}} : bus.i_ex_m_write_data;
    rword     = mem[idx];
    rbyte     = rword[{off, 3'b000} +: 8];
    rhalf     = off[1] ? rword[31:16] : rword[15:0];
    ext       = is_byte ? {{24{~uns & rbyte[7]}}, rbyte} :
                is_half ? {{16{~uns & rhalf[15]}}, rhalf} : rword;
    load      = (bus.i_ex_m_mem_read & ~misal) ? ext : 32'h0;
  end

  // next MEM/WB contents; everything holds while the step enable is low
  always_comb begin
    read_data_d  = i_clk_en ? load : read_data_q;
    alu_result_d = i_clk_en ? bus.i_ex_m_alu_result : alu_result_q;
    rd_d         = i_clk_en ? bus.i_ex_m_rd : rd_q;
    mem_to_reg_d = i_clk_en ? bus.i_ex_m_mem_to_reg : mem_to_reg_q;
    reg_write_d  = i_clk_en ? bus.i_ex_m_reg_write & ~fault_now : reg_write_q;
    halt_d       = i_clk_en ? bus.i_ex_m_halt : halt_q;
    fault_d      = fault_q | (i_clk_en & fault_now);
  end

  // MEM/WB register and sticky fault flag
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      read_data_q  <= 32'h0;
      alu_result_q <= 32'h0;
      rd_q         <= 5'h0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      halt_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      rd_q         <= rd_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      halt_q       <= halt_d;
      fault_q      <= fault_d;
    end
  end

  // byte-lane store; contents survive reset but no write lands while reset is low
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (i_reset && do_store)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
  end

  assign o_du_data              = mem[i_du_addr];
  assign o_mem_fault            = fault_q;
  assign bus.o_m_wb_read_data   = read_data_q;
  assign bus.o_m_wb_alu_result  = alu_result_q;
  assign bus.o_m_wb_rd          = rd_q;
  assign bus.o_m_wb_mem_to_reg  = mem_to_reg_q;
  assign bus.o_m_wb_reg_write   = reg_write_q;
  assign bus.o_m_wb_halt        = halt_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of loads, stores, faults, stall and reset
module tb_mem_stage;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic [7:0] du_addr = 8'h0;
  logic [31:0] du_data;
  logic       fault;
  int         checks = 0;
  int         failures = 0;

  mem_stage_if bus();

  mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_clk_en(clk_en), .bus(bus),
    .i_du_addr(du_addr), .o_du_data(du_data), .o_mem_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                    input logic mr, input logic mw, input logic m2r, input logic rw,
                    input logic [2:0] bhw, input logic halt);
    bus.i_ex_m_alu_result = a;
    bus.i_ex_m_write_data = wd;
    bus.i_ex_m_rd         = rd;
    bus.i_ex_m_mem_read   = mr;
    bus.i_ex_m_mem_write  = mw;
    bus.i_ex_m_mem_to_reg = m2r;
    bus.i_ex_m_reg_write  = rw;
    bus.i_ex_m_bhw_type   = bhw;
    bus.i_ex_m_halt       = halt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    op(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 3'b010, 0);
    step();
    step();
    check("reset_read_data", bus.o_m_wb_read_data, 32'h0);
    check("reset_alu", bus.o_m_wb_alu_result, 32'h0);
    check("reset_fault", {31'h0, fault}, 32'h0);
    #3 rst_n = 1'b1;
    op(32'h10, 32'h8BADF00D, 5'd1, 0, 1, 0, 0, 3'b010, 0);
    du_addr = 8'd4;
    step();
    check("sw_du", du_data, 32'h8BADF00D);
    op(32'h10, 32'h0, 5'd5, 1, 0, 1, 1, 3'b010, 0);
    step();
    check("lw_data", bus.o_m_wb_read_data, 32'h8BADF00D);
    check("lw_rd", {27'h0, bus.o_m_wb_rd}, 32'd5);
    check("lw_regwrite", {31'h0, bus.o_m_wb_reg_write}, 32'h1);
    check("lw_m2r", {31'h0, bus.o_m_wb_mem_to_reg}, 32'h1);
    op(32'h13, 32'h0, 5'd6, 1, 0, 1, 1, 3'b000, 0);
    step();
    check("lb_13", bus.o_m_wb_read_data, 32'hFFFFFF8B);
    op(32'h11, 32'h0, 5'd6, 1, 0, 1, 1, 3'b100, 0);
    step();
    check("lbu_11", bus.o_m_wb_read_data, 32'h000000F0);
    op(32'h12, 32'h0, 5'd6, 1, 0, 1, 1, 3'b001, 0);
    step();
    check("lh_12", bus.o_m_wb_read_data, 32'hFFFF8BAD);
    op(32'h12, 32'h0, 5'd6, 1, 0, 1, 1, 3'b101, 0);
    step();
    check("lhu_12", bus.o_m_wb_read_data, 32'h00008BAD);
    op(32'h11, 32'h1234565A, 5'd0, 0, 1, 0, 0, 3'b000, 0);
    step();
    op(32'h10, 32'h0, 5'd7, 1, 0, 1, 1, 3'b010, 0);
    step();
    check("sb_then_lw", bus.o_m_wb_read_data, 32'h8BAD5A0D);
    op(32'h0000DEAD, 32'hFFFFFFFF, 5'd8, 0, 0, 0, 1, 3'b010, 0);
    step();
    check("alu_read_zero", bus.o_m_wb_read_data, 32'h0);
    check("alu_pass", bus.o_m_wb_alu_result, 32'h0000DEAD);
    check("no_fault_yet", {31'h0, fault}, 32'h0);
    op(32'h14, 32'h0, 5'd0, 0, 1, 0, 0, 3'b010, 0);
    step();
    op(32'h16, 32'h0000BEEF, 5'd0, 0, 1, 0, 0, 3'b001, 0);
    step();
    op(32'h415, 32'h00000011, 5'd0, 0, 1, 0, 0, 3'b000, 0);
    step();
    du_addr = 8'd5;
    #1 check("sh_sb_wrap", du_data, 32'hBEEF1100);
    op(32'h12, 32'h0, 5'd9, 1, 0, 1, 1, 3'b010, 0);
    step();
    check("mis_lw_data", bus.o_m_wb_read_data, 32'h0);
    check("mis_lw_regwrite", {31'h0, bus.o_m_wb_reg_write}, 32'h0);
    check("mis_lw_fault", {31'h0, fault}, 32'h1);
    check("mis_lw_alu", bus.o_m_wb_alu_result, 32'h12);
    op(32'h11, 32'h00007777, 5'd0, 0, 1, 0, 0, 3'b001, 0);
    du_addr = 8'd4;
    step();
    check("mis_sh_nowrite", du_data, 32'h8BAD5A0D);
    op(32'h10, 32'h0, 5'd10, 1, 0, 1, 1, 3'b010, 0);
    step();
    check("after_fault_rw", {31'h0, bus.o_m_wb_reg_write}, 32'h1);
    check("fault_sticky", {31'h0, fault}, 32'h1);
    op(32'h20, 32'h11111111, 5'd3, 0, 1, 0, 0, 3'b010, 0);
    du_addr = 8'd8;
    step();
    check("sw20_pre", du_data, 32'h11111111);
    op(32'h20, 32'hCAFEBABE, 5'd9, 0, 1, 0, 0, 3'b010, 1);
    clk_en = 1'b0;
    step();
    step();
    step();
    check("stall_nowrite", du_data, 32'h11111111);
    check("stall_rd", {27'h0, bus.o_m_wb_rd}, 32'd3);
    check("stall_halt", {31'h0, bus.o_m_wb_halt}, 32'h0);
    clk_en = 1'b1;
    #1 check("du_old_before_edge", du_data, 32'h11111111);
    step();
    check("stall_commit", du_data, 32'hCAFEBABE);
    check("stall_rd_new", {27'h0, bus.o_m_wb_rd}, 32'd9);
    check("stall_halt_new", {31'h0, bus.o_m_wb_halt}, 32'h1);
    op(32'h20, 32'h22222222, 5'd4, 1, 1, 1, 1, 3'b010, 0);
    step();
    check("rw_old_data", bus.o_m_wb_read_data, 32'hCAFEBABE);
    check("rw_new_mem", du_data, 32'h22222222);
    op(32'h20, 32'h0BADBEEF, 5'd11, 0, 1, 0, 1, 3'b010, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_rd", {27'h0, bus.o_m_wb_rd}, 32'h0);
    check("rst_async_alu", bus.o_m_wb_alu_result, 32'h0);
    check("rst_async_fault", {31'h0, fault}, 32'h0);
    step();
    check("rst_no_store", du_data, 32'h22222222);
    #3 rst_n = 1'b1;
    op(32'h20, 32'h0, 5'd12, 1, 0, 1, 1, 3'b010, 1);
    step();
    check("post_rst_lw", bus.o_m_wb_read_data, 32'h22222222);
    check("post_rst_halt", {31'h0, bus.o_m_wb_halt}, 32'h1);
    check("post_rst_fault", {31'h0, fault}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
